// File: rtl/csa_acc_pkg.sv
// Shared types and size helpers for the carry-save stream accumulator.
// Holds the controller state encoding and the chunk-count / chunk-index-width helpers.
package csa_acc_pkg;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    function automatic int num_chunks(input int acc_w, input int chunk);
        return acc_w / chunk;
    endfunction

    // A single-chunk resolve still needs a 1-bit counter.
    function automatic int chunk_idx_w(input int acc_w, input int chunk);
        int nc;
        nc = acc_w / chunk;
        return (nc > 1) ? $clog2(nc) : 1;
    endfunction

endpackage

// File: rtl/csa_chunk_adder.sv
// Purely combinational CHUNK-bit adder with carry in and out.
// Zero latency; no handshake, used for one resolve slice per cycle.
module csa_chunk_adder #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_ci,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_co
);

    assign {o_co, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_ci};

endmodule

// File: rtl/csa_stream_accumulator.sv
// Carry-save packet accumulator: one 3:2 compression per accepted operand, then a chunked
// carry-propagate resolve (ACC_W/CHUNK cycles + 1 commit cycle) and a held valid/ready result.
// Backpressure: in_ready only in ACCUM; result held until out_ready. CSA_OVF_DETECT_EN adds out_ovf.
module csa_stream_accumulator
    import csa_acc_pkg::*;
#(
    parameter int N     = 4,
    parameter int ACC_W = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef CSA_OVF_DETECT_EN
    output logic             out_ovf,
`endif
    output logic [ACC_W-1:0] out_sum
);

    localparam int NC    = num_chunks(ACC_W, CHUNK);
    localparam int IDX_W = chunk_idx_w(ACC_W, CHUNK);
    localparam logic [IDX_W-1:0] LAST_K = IDX_W'(NC - 1);

    generate
        if (ACC_W % CHUNK != 0) begin : g_bad_chunk
            $error("csa_stream_accumulator: ACC_W must be a multiple of CHUNK");
        end
        if (ACC_W < N) begin : g_bad_width
            $error("csa_stream_accumulator: ACC_W must be >= N");
        end
    endgenerate

    state_t             r_state;
    logic [ACC_W-1:0]   r_s;
    logic [ACC_W-1:0]   r_c;
    logic [ACC_W-1:0]   r_res;
    logic [IDX_W-1:0]   r_k;
    logic               r_ci;
    logic               r_commit;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [ACC_W-1:0]   r_out_sum;

    logic [ACC_W-1:0]   w_x;
    logic [ACC_W-1:0]   w_maj;
    logic [CHUNK-1:0]   w_s_chunk;
    logic [CHUNK-1:0]   w_c_chunk;
    logic [CHUNK-1:0]   w_chunk_sum;
    logic               w_co;
    logic               w_accept;
    logic               w_out_hs;
    logic               w_final_chunk;

    assign w_x           = ACC_W'(in_data);
    assign w_maj         = (r_s & r_c) | (r_c & w_x) | (w_x & r_s);
    assign w_s_chunk     = r_s[r_k*CHUNK +: CHUNK];
    assign w_c_chunk     = r_c[r_k*CHUNK +: CHUNK];
    assign w_accept      = in_valid & r_in_ready;
    assign w_out_hs      = r_out_valid & out_ready;
    assign w_final_chunk = (r_state == RESOLVE) && !r_commit && (r_k == LAST_K);

    csa_chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .i_a   (w_s_chunk),
        .i_b   (w_c_chunk),
        .i_ci  (r_ci),
        .o_sum (w_chunk_sum),
        .o_co  (w_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ACCUM;
            r_s         <= '0;
            r_c         <= '0;
            r_res       <= '0;
            r_k         <= '0;
            r_ci        <= 1'b0;
            r_commit    <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        r_s <= r_s ^ r_c ^ w_x;
                        r_c <= w_maj << 1;
                        if (in_last) begin
                            r_state    <= RESOLVE;
                            r_in_ready <= 1'b0;
                            r_k        <= '0;
                            r_ci       <= 1'b0;
                            r_commit   <= 1'b0;
                        end
                    end
                end
                RESOLVE: begin
                    // Chunks resolve LSB first; one extra commit cycle registers the result.
                    if (!r_commit) begin
                        r_res[r_k*CHUNK +: CHUNK] <= w_chunk_sum;
                        r_ci <= w_co;
                        if (r_k == LAST_K) begin
                            r_commit <= 1'b1;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end else begin
                        r_commit    <= 1'b0;
                        r_out_sum   <= r_res;
                        r_out_valid <= 1'b1;
                        r_state     <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (w_out_hs) begin
                        r_out_valid <= 1'b0;
                        r_s         <= '0;
                        r_c         <= '0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ACCUM;
                    end
                end
                default: begin
                    r_state    <= ACCUM;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef CSA_OVF_DETECT_EN
    logic r_drop;
    logic r_out_ovf;

    // Unsigned operands: any weight lost off the top means the true total reached 2^ACC_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop    <= 1'b0;
            r_out_ovf <= 1'b0;
        end else if ((r_state == ACCUM) && w_accept) begin
            r_drop <= r_drop | w_maj[ACC_W-1];
        end else if (w_final_chunk) begin
            r_drop <= r_drop | w_co;
        end else if ((r_state == RESOLVE) && r_commit) begin
            r_out_ovf <= r_drop;
        end else if ((r_state == OUTPUT) && w_out_hs) begin
            r_drop    <= 1'b0;
            r_out_ovf <= 1'b0;
        end
    end

    assign out_ovf = r_out_ovf;
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Directed self-checking bench for csa_stream_accumulator (N=4, ACC_W=8, CHUNK=2).
module tb_csa_stream_accumulator;

    typedef logic [3:0] op_arr_t [18];

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
`ifdef CSA_OVF_DETECT_EN
    logic       out_ovf;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    csa_stream_accumulator #(.N(4), .ACC_W(8), .CHUNK(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef CSA_OVF_DETECT_EN
        .out_ovf   (out_ovf),
`endif
        .out_sum   (out_sum)
    );

    // Drives one operand per cycle; returns at the falling edge after the last accept.
    task automatic send_pkt(input op_arr_t ops, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = ops[i];
            in_last  = (i == n - 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 4'h0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handshake;
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 8'h00) begin
            fails++;
            $display("FAIL reset_state: out_valid=%b in_ready=%b out_sum=%h, want 0 1 00", out_valid, in_ready, out_sum);
        end
`ifdef CSA_OVF_DETECT_EN
        tests++;
        if (out_ovf !== 1'b0) begin
            fails++;
            $display("FAIL reset_ovf: got %b want 0", out_ovf);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_single;
        op_arr_t ops;
        int      lat;
        ops = '{default: 4'h0};
        ops[0] = 4'hF;
        send_pkt(ops, 1);
        wait_out(lat);
        tests++;
        if (lat != 5) begin
            fails++;
            $display("FAIL single_latency: got %0d cycles want 5", lat);
        end
        tests++;
        if (out_sum !== 8'h0F) begin
            fails++;
            $display("FAIL single_sum: got %h want 0f", out_sum);
        end
`ifdef CSA_OVF_DETECT_EN
        tests++;
        if (out_ovf !== 1'b0) begin
            fails++;
            $display("FAIL single_ovf: got %b want 0", out_ovf);
        end
`endif
        handshake();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL single_handshake: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back;
        op_arr_t ops;
        int      lat;
        ops = '{default: 4'h0};
        ops[0] = 4'd3; ops[1] = 4'd5; ops[2] = 4'd7; ops[3] = 4'd9;
        send_pkt(ops, 4);
        wait_out(lat);
        tests++;
        if (out_valid !== 1'b1 || out_sum !== 8'h18 || lat != 5) begin
            fails++;
            $display("FAIL b2b_sum: valid=%b sum=%h lat=%0d want 1 18 5", out_valid, out_sum, lat);
        end
        handshake();
    endtask

    task automatic test_wrap;
        op_arr_t ops;
        int      lat;
        ops = '{default: 4'hF};
        send_pkt(ops, 18);
        wait_out(lat);
        tests++;
        if (out_valid !== 1'b1 || out_sum !== 8'h0E) begin
            fails++;
            $display("FAIL wrap18_sum: valid=%b sum=%h want 1 0e", out_valid, out_sum);
        end
`ifdef CSA_OVF_DETECT_EN
        tests++;
        if (out_ovf !== 1'b1) begin
            fails++;
            $display("FAIL wrap18_ovf: got %b want 1", out_ovf);
        end
`endif
        handshake();
        send_pkt(ops, 17);
        wait_out(lat);
        tests++;
        if (out_valid !== 1'b1 || out_sum !== 8'hFF) begin
            fails++;
            $display("FAIL wrap17_sum: valid=%b sum=%h want 1 ff", out_valid, out_sum);
        end
`ifdef CSA_OVF_DETECT_EN
        tests++;
        if (out_ovf !== 1'b0) begin
            fails++;
            $display("FAIL wrap17_ovf: got %b want 0", out_ovf);
        end
`endif
        handshake();
    endtask

    task automatic test_backpressure;
        op_arr_t ops;
        int      lat;
        ops = '{default: 4'h0};
        ops[0] = 4'd6; ops[1] = 4'd1;
        send_pkt(ops, 2);
        wait_out(lat);
        in_valid = 1'b1; in_data = 4'h5; in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b1 || out_sum !== 8'h07 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL hold_cycle%0d: valid=%b sum=%h in_ready=%b want 1 07 0", i, out_valid, out_sum, in_ready);
            end
        end
        in_valid = 1'b0; in_last = 1'b0; in_data = 4'h0;
        handshake();
        ops[0] = 4'd2;
        send_pkt(ops, 1);
        wait_out(lat);
        tests++;
        if (out_valid !== 1'b1 || out_sum !== 8'h02) begin
            fails++;
            $display("FAIL hold_no_consume: valid=%b sum=%h want 1 02", out_valid, out_sum);
        end
        handshake();
    endtask

    task automatic test_reset_mid;
        op_arr_t ops;
        int      lat;
        ops = '{default: 4'h0};
        ops[0] = 4'd7; ops[1] = 4'd7;
        send_pkt(ops, 2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 8'h00) begin
            fails++;
            $display("FAIL rst_resolve: valid=%b in_ready=%b sum=%h want 0 1 00", out_valid, in_ready, out_sum);
        end
        @(negedge clk);
        rst = 1'b0;
        ops[0] = 4'd9;
        send_pkt(ops, 1);
        wait_out(lat);
        rst = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_sum !== 8'h00) begin
            fails++;
            $display("FAIL rst_output: valid=%b sum=%h want 0 00", out_valid, out_sum);
        end
        @(negedge clk);
        rst = 1'b0;
        ops[0] = 4'd1; ops[1] = 4'd2;
        send_pkt(ops, 2);
        wait_out(lat);
        tests++;
        if (out_valid !== 1'b1 || out_sum !== 8'h03 || lat != 5) begin
            fails++;
            $display("FAIL rst_next_pkt: valid=%b sum=%h lat=%0d want 1 03 5", out_valid, out_sum, lat);
        end
        handshake();
    endtask

    task automatic test_no_leak;
        op_arr_t ops;
        int      lat;
        ops = '{default: 4'hF};
        send_pkt(ops, 18);
        wait_out(lat);
        handshake();
        out_ready = 1'b1;
        ops = '{default: 4'h0};
        ops[0] = 4'd2;
        send_pkt(ops, 1);
        wait_out(lat);
        tests++;
        if (out_valid !== 1'b1 || out_sum !== 8'h02) begin
            fails++;
            $display("FAIL leak_first: valid=%b sum=%h want 1 02", out_valid, out_sum);
        end
`ifdef CSA_OVF_DETECT_EN
        tests++;
        if (out_ovf !== 1'b0) begin
            fails++;
            $display("FAIL leak_ovf: got %b want 0", out_ovf);
        end
`endif
        ops[0] = 4'd4;
        send_pkt(ops, 1);
        wait_out(lat);
        tests++;
        if (out_valid !== 1'b1 || out_sum !== 8'h04 || lat != 5) begin
            fails++;
            $display("FAIL leak_second: valid=%b sum=%h lat=%0d want 1 04 5", out_valid, out_sum, lat);
        end
        @(negedge clk);
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL leak_drain: valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_no_leak();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
